// File: rtl/hazard_unit.sv
// Load-use hazard detector and stall controller sitting beside the ID stage.
// When an ID instruction reads the rd of a load in EX, it holds IF/ID and bubbles
// EX until the load's data arrives in MEM. It includes a wait timeout and a
// saturating stall counter.
module hazard_unit #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_valid_i,
  input  logic             ex_is_load_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_ack_i,
  output logic             stall_o,
  output logic             bubble_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int unsigned WAIT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              hit;
  logic              stall;

  // ID reads the destination of a load in EX; x0 never hazards
  always_comb begin
    hit = id_valid_i & ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) &
          ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
           (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
  end

  // Next-state, wait counter, timeout and stall decode
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      wait_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // In the abort cycle after a timeout (err_q high), the held ID
          // instruction is released rather than re-stalled.
          if (hit && !err_q) begin
            stall   = 1'b1;
            state_d = MEM_WAIT;
            wait_d  = '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            state_d = IDLE;
            wait_d  = '0;
          end else begin
            stall = 1'b1;
            if (TO_EN && (wait_q == WAIT_LAST)) begin
              state_d = IDLE;
              wait_d  = '0;
              err_d   = 1'b1;
            end else if (TO_EN) begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          wait_d  = '0;
        end
      endcase
    end
  end

  // Stall and bubble are the same signal, gated low while reset is held
  always_comb begin
    stall_o  = stall & rst_ni;
    bubble_o = stall & rst_ni;
  end

  // State, wait counter and error pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (stall_o && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = cnt_q;

endmodule
